// File: rtl/vpu_pkg.sv
// vpu_pkg: shared vector-unit constants and sequencer state encoding
package vpu_pkg;
  localparam int MAX_VL  = 8;
  localparam int IDX_W   = 3;
  localparam int VLR_W   = 32;
  localparam int RADDR_W = 5;
  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_e;
endpackage

// File: rtl/vseq_elem_counter.sv
// vseq_elem_counter: element index counter with load-zero, increment and last flag
module vseq_elem_counter
  import vpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [IDX_W:0]   vl_eff,
  output logic [IDX_W-1:0] idx,
  output logic             last
);
  logic [IDX_W-1:0] idx_q, idx_d;
  assign idx  = idx_q;
  assign last = {1'b0, idx_q} == vl_eff - 1'b1;
  // hold on the last element so the index never leaves the valid lane range
  always_comb idx_d = clr ? '0 : (inc && !last) ? idx_q + 1'b1 : idx_q;
  // index register
  always_ff @(posedge clk or posedge rst)
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
endmodule

// File: rtl/vector_exec_sequencer.sv
// vector_exec_sequencer: orders read, execute and per-element write-back for one vector instruction
module vector_exec_sequencer
  import vpu_pkg::*;
(
  input  logic               clk,
  input  logic               pc_rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [VLR_W-1:0]   vlr,
  input  logic [RADDR_W-1:0] vd,
  output logic               rd_ena,
  input  logic               rd_done,
  output logic               ex_ena,
  input  logic               ex_done,
  output logic               wb_we,
  output logic [IDX_W-1:0]   wb_idx,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [IDX_W:0]     vl_eff,
  output logic               seq_busy,
  output logic               seq_done
);
  state_e             state_q, state_d;
  logic [RADDR_W-1:0] vd_q, vd_d;
  logic [IDX_W:0]     vl_q, vl_d;
  logic               clr, last;
  assign instr_ready = state_q == IDLE;
  assign rd_ena      = state_q == READ;
  assign ex_ena      = state_q == EXEC;
  assign wb_we       = state_q == WRITE;
  assign seq_done    = state_q == DONE;
  assign seq_busy    = state_q != IDLE;
  assign wb_addr     = vd_q;
  assign vl_eff      = vl_q;
  vseq_elem_counter u_cnt (
    .clk    (clk),
    .rst    (pc_rst),
    .clr    (clr),
    .inc    (wb_we),
    .vl_eff (vl_q),
    .idx    (wb_idx),
    .last   (last)
  );
  // next state, operand latching and counter clear; full-width clamp avoids wrap of large vlr
  always_comb begin
    state_d = state_q;
    vd_d    = vd_q;
    vl_d    = vl_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: if (instr_valid) begin
        vd_d    = vd;
        vl_d    = (vlr > VLR_W'(MAX_VL)) ? (IDX_W+1)'(MAX_VL) : vlr[IDX_W:0];
        state_d = (vlr == '0) ? DONE : READ;
      end
      READ:  if (rd_done) state_d = EXEC;
      EXEC:  if (ex_done) begin
        state_d = WRITE;
        clr     = 1'b1;
      end
      WRITE: if (last) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and latched instruction fields
  always_ff @(posedge clk or posedge pc_rst)
    if (pc_rst) begin
      state_q <= IDLE;
      vd_q    <= '0;
      vl_q    <= '0;
    end else begin
      state_q <= state_d;
      vd_q    <= vd_d;
      vl_q    <= vl_d;
    end
endmodule
